// File: rtl/wb_cfg_master.sv
// Wishbone classic master: valid/ready commands in, single WB cycles out, with retry, a bus watchdog and an optional irq wait.
// Define WB_CFG_IRQ_TIMEOUT_EN to bound the irq wait by IRQ_TIMEOUT cycles (status 100 on expiry).
module wb_cfg_master #(
  parameter int TIMEOUT     = 16,
  parameter int MAX_RETRY   = 3,
  parameter int RETRY_GAP   = 2,
  parameter int IRQ_TIMEOUT = 64
) (
  input  logic        p_clk,
  input  logic        p_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  input  logic        cmd_wait_irq,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic [2:0]  rsp_status,
  output logic        busy,
  input  logic        irq_i,
  output logic [31:0] p_wb_ADR_O,
  output logic [31:0] p_wb_DAT_O,
  input  logic [31:0] p_wb_DAT_I,
  output logic [3:0]  p_wb_SEL_O,
  output logic        p_wb_WE_O,
  output logic        p_wb_CYC_O,
  output logic        p_wb_STB_O,
  output logic        p_wb_LOCK_O,
  input  logic        p_wb_ACK_I,
  input  logic        p_wb_ERR_I,
  input  logic        p_wb_RTY_I
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GW = $clog2(RETRY_GAP + 1);
  localparam int IW = $clog2(IRQ_TIMEOUT + 1);

  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
  localparam logic [GW-1:0] GAP_LAST   = GW'(RETRY_GAP - 1);
  localparam logic [IW-1:0] IRQ_LAST   = IW'(IRQ_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_BUS, S_GAP, S_WAIT_IRQ, S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic          wait_irq_q, wait_irq_d;
  logic [31:0]   rsp_dat_q, rsp_dat_d;
  logic [2:0]    rsp_status_q, rsp_status_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [RW-1:0] retry_cnt_q, retry_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [IW-1:0] irq_cnt_q, irq_cnt_d;

  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) begin
      state_q      <= S_IDLE;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      wait_irq_q   <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= '0;
      wait_cnt_q   <= '0;
      retry_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      irq_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      wait_irq_q   <= wait_irq_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
      wait_cnt_q   <= wait_cnt_d;
      retry_cnt_q  <= retry_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      irq_cnt_q    <= irq_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    we_d         = we_q;
    wait_irq_d   = wait_irq_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
    wait_cnt_d   = wait_cnt_q;
    retry_cnt_d  = retry_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    irq_cnt_d    = irq_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          adr_d       = cmd_adr;
          dat_d       = cmd_dat;
          sel_d       = cmd_sel;
          we_d        = cmd_we;
          wait_irq_d  = cmd_wait_irq;
          retry_cnt_d = '0;
          wait_cnt_d  = '0;
          state_d     = S_BUS;
        end
      end
      S_BUS: begin
        // Any termination on the watchdog's final edge still takes precedence.
        if (p_wb_ERR_I) begin
          rsp_dat_d    = '0;
          rsp_status_d = 3'b001;
          state_d      = S_RESP;
        end else if (p_wb_RTY_I) begin
          if (retry_cnt_q == RETRY_LAST) begin
            rsp_dat_d    = '0;
            rsp_status_d = 3'b011;
            state_d      = S_RESP;
          end else begin
            retry_cnt_d = retry_cnt_q + 1'b1;
            gap_cnt_d   = '0;
            state_d     = S_GAP;
          end
        end else if (p_wb_ACK_I) begin
          rsp_dat_d    = we_q ? 32'h0 : p_wb_DAT_I;
          rsp_status_d = 3'b000;
          irq_cnt_d    = '0;
          state_d      = wait_irq_q ? S_WAIT_IRQ : S_RESP;
        end else if (wait_cnt_q == WAIT_LAST) begin
          rsp_dat_d    = '0;
          rsp_status_d = 3'b010;
          state_d      = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          wait_cnt_d = '0;
          state_d    = S_BUS;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      S_WAIT_IRQ: begin
        // The counter saturates so an unbounded wait cannot wrap it.
        if (irq_i) begin
          state_d = S_RESP;
        end else if (irq_cnt_q == IRQ_LAST) begin
`ifdef WB_CFG_IRQ_TIMEOUT_EN
          rsp_status_d = 3'b100;
          state_d      = S_RESP;
`endif
        end else begin
          irq_cnt_d = irq_cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_dat     = rsp_dat_q;
  assign rsp_status  = rsp_status_q;
  assign p_wb_CYC_O  = (state_q == S_BUS);
  assign p_wb_STB_O  = (state_q == S_BUS);
  assign p_wb_ADR_O  = adr_q;
  assign p_wb_DAT_O  = dat_q;
  assign p_wb_SEL_O  = sel_q;
  assign p_wb_WE_O   = we_q;
  assign p_wb_LOCK_O = 1'b0;

endmodule

// File: tb/tb_wb_cfg_master.sv
// Bench for wb_cfg_master: scripted WB slave plus a transaction-level reference model.
module tb_wb_cfg_master;
  localparam int TIMEOUT = 16, MAX_RETRY = 3, RETRY_GAP = 2, IRQ_TIMEOUT = 64;

  logic        p_clk = 1'b0;
  logic        p_reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0, cmd_wait_irq = 1'b0, rsp_ready = 1'b1;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        cmd_ready, rsp_valid, busy;
  logic [31:0] rsp_dat;
  logic [2:0]  rsp_status;
  logic        irq_i = 1'b0;
  logic [31:0] p_wb_ADR_O, p_wb_DAT_O;
  logic [31:0] p_wb_DAT_I = '0;
  logic [3:0]  p_wb_SEL_O;
  logic        p_wb_WE_O, p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O;
  logic        p_wb_ACK_I = 1'b0, p_wb_ERR_I = 1'b0, p_wb_RTY_I = 1'b0;

  always #5 p_clk = ~p_clk;

  wb_cfg_master #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .RETRY_GAP(RETRY_GAP),
                  .IRQ_TIMEOUT(IRQ_TIMEOUT)) dut (
    .p_clk(p_clk), .p_reset(p_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_adr(cmd_adr),
    .cmd_dat(cmd_dat), .cmd_sel(cmd_sel), .cmd_wait_irq(cmd_wait_irq),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_status(rsp_status),
    .busy(busy), .irq_i(irq_i),
    .p_wb_ADR_O(p_wb_ADR_O), .p_wb_DAT_O(p_wb_DAT_O), .p_wb_DAT_I(p_wb_DAT_I),
    .p_wb_SEL_O(p_wb_SEL_O), .p_wb_WE_O(p_wb_WE_O), .p_wb_CYC_O(p_wb_CYC_O),
    .p_wb_STB_O(p_wb_STB_O), .p_wb_LOCK_O(p_wb_LOCK_O),
    .p_wb_ACK_I(p_wb_ACK_I), .p_wb_ERR_I(p_wb_ERR_I), .p_wb_RTY_I(p_wb_RTY_I)
  );

  int checks = 0, failures = 0;

  // Slave script: per attempt, kind (0 none, 1 ACK, 2 ERR, 3 RTY) and STB cycles before answering.
  int          plan_kind [8];
  int          plan_delay[8];
  int          irq_d = 0;
  int          txn_id = 0;
  logic [31:0] cur_adr = '0, cur_dat = '0;
  logic [3:0]  cur_sel = '0;
  logic        cur_we = 1'b0, cur_wi = 1'b0;
  logic [31:0] mem     [16] = '{default: 32'h0};
  logic [31:0] ref_mem [16] = '{default: 32'h0};
  int          pulses[$], gaps[$];
  int          bus_bad = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scripted slave and bus monitor
  int seen_id = 0, att = 0, stb_cnt = 0, cur_len = 0, gap_run = 0, irq_cnt = 0;
  bit was_stb = 0, in_gap = 0, irq_arm = 0;
  always @(negedge p_clk) begin
    if (seen_id != txn_id) begin
      seen_id = txn_id; att = 0; stb_cnt = 0; cur_len = 0; in_gap = 0; gap_run = 0;
      irq_arm = 0; irq_i = 1'b0; bus_bad = 0;
      pulses.delete(); gaps.delete();
    end
    p_wb_ACK_I = 1'b0; p_wb_ERR_I = 1'b0; p_wb_RTY_I = 1'b0;
    p_wb_DAT_I = $urandom;
    if (p_wb_STB_O) begin
      if (in_gap) begin gaps.push_back(gap_run); in_gap = 0; end
      if (p_wb_CYC_O !== 1'b1 || p_wb_ADR_O !== cur_adr || p_wb_DAT_O !== cur_dat ||
          p_wb_SEL_O !== cur_sel || p_wb_WE_O !== cur_we) bus_bad++;
      if (att < 8 && plan_kind[att] != 0 && stb_cnt == plan_delay[att]) begin
        case (plan_kind[att])
          1: begin
            p_wb_ACK_I = 1'b1;
            if (p_wb_WE_O) mem[p_wb_ADR_O[5:2]] = merge(mem[p_wb_ADR_O[5:2]], p_wb_DAT_O, p_wb_SEL_O);
            else p_wb_DAT_I = mem[p_wb_ADR_O[5:2]];
            if (cur_wi) begin irq_arm = 1; irq_cnt = irq_d; end
          end
          2: p_wb_ERR_I = 1'b1;
          default: p_wb_RTY_I = 1'b1;
        endcase
      end
      stb_cnt++; cur_len++;
    end else if (was_stb) begin
      pulses.push_back(cur_len);
      cur_len = 0; stb_cnt = 0; att++; in_gap = 1; gap_run = 1;
    end else if (in_gap) begin
      gap_run++;
    end
    if (irq_arm) begin
      if (irq_cnt == 0) begin irq_i = 1'b1; irq_arm = 0; end
      else irq_cnt--;
    end
    was_stb = p_wb_STB_O;
  end

  task automatic set_plan(input int k0, d0, k1, d1, k2, d2, k3, d3);
    plan_kind  = '{k0, k1, k2, k3, 0, 0, 0, 0};
    plan_delay = '{d0, d1, d2, d3, 0, 0, 0, 0};
  endtask

  task automatic run_txn(input string tag, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input logic wi,
                         input int hold);
    int exp_len[$];
    int total, n, k, w;
    logic [2:0]  est;
    logic [31:0] edat;
    bit          have_dat;
    total = 0; est = 3'b000; edat = '0; have_dat = 0;
    for (int a = 0; a <= MAX_RETRY; a++) begin
      k = plan_kind[a];
      if (k == 0) begin exp_len.push_back(TIMEOUT); total += TIMEOUT; est = 3'b010; break; end
      exp_len.push_back(plan_delay[a] + 1);
      total += plan_delay[a] + 1;
      if (k == 2) begin est = 3'b001; break; end
      if (k == 3) begin
        if (a == MAX_RETRY) begin est = 3'b011; break; end
        total += RETRY_GAP;
        continue;
      end
      have_dat = 1;
      edat = we ? 32'h0 : ref_mem[adr[5:2]];
      if (we) ref_mem[adr[5:2]] = merge(ref_mem[adr[5:2]], dat, sel);
      if (wi) begin
        w = (irq_d < 1) ? 1 : irq_d;
`ifdef WB_CFG_IRQ_TIMEOUT_EN
        if (w > IRQ_TIMEOUT) begin w = IRQ_TIMEOUT; est = 3'b100; end
`endif
        total += w;
      end
      break;
    end

    @(negedge p_clk);
    cur_adr = adr; cur_dat = dat; cur_sel = sel; cur_we = we; cur_wi = wi;
    txn_id++;
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_wait_irq = wi;
    cmd_valid = 1'b1;
    rsp_ready = (hold == 0);
    check({tag, "/cmd_ready_idle"}, cmd_ready, 1);
    @(negedge p_clk);
    cmd_valid = 1'b0; cmd_adr = $urandom; cmd_dat = $urandom; cmd_we = ~we; cmd_sel = ~sel;
    n = 1;
    while (!rsp_valid && n < 400) begin @(negedge p_clk); n++; end
    check({tag, "/latency"}, n, total + 1);
    check({tag, "/status"}, rsp_status, est);
    if (have_dat) check({tag, "/rsp_dat"}, rsp_dat, edat);
    check({tag, "/cmd_ready_busy"}, {busy, cmd_ready}, 2'b10);
    for (int h = 0; h < hold; h++) begin
      @(negedge p_clk);
      check({tag, "/hold_valid"}, {rsp_valid, cmd_ready}, 2'b10);
      check({tag, "/hold_status"}, rsp_status, est);
      if (have_dat) check({tag, "/hold_dat"}, rsp_dat, edat);
    end
    rsp_ready = 1'b1;
    @(negedge p_clk);
    check({tag, "/after_rsp"}, {rsp_valid, cmd_ready, busy}, 3'b010);
    check({tag, "/n_pulses"}, pulses.size(), exp_len.size());
    for (int i = 0; i < exp_len.size() && i < pulses.size(); i++)
      check({tag, "/pulse_len"}, pulses[i], exp_len[i]);
    check({tag, "/n_gaps"}, gaps.size(), exp_len.size() - 1);
    for (int i = 0; i < gaps.size(); i++) check({tag, "/gap_len"}, gaps[i], RETRY_GAP);
    check({tag, "/bus_stable"}, bus_bad, 0);
  endtask

  initial begin
    int r;
    logic [31:0] ra, rd;
    set_plan(1, 0, 0, 0, 0, 0, 0, 0);
    p_reset = 1'b1;
    repeat (2) @(negedge p_clk);
    check("reset/bus_ctl", {p_wb_CYC_O, p_wb_STB_O, p_wb_WE_O, p_wb_LOCK_O}, 4'b0000);
    check("reset/bus_data", {p_wb_ADR_O, p_wb_DAT_O, p_wb_SEL_O}, '0);
    check("reset/rsp", {rsp_valid, rsp_dat, rsp_status, busy}, '0);
    p_reset = 1'b0;
    @(negedge p_clk);
    check("reset/cmd_ready", cmd_ready, 1);

    set_plan(1, 0, 0, 0, 0, 0, 0, 0);
    run_txn("write_ack", 1'b1, 32'h0, 32'hDEADBEEF, 4'hF, 1'b0, 0);
    run_txn("read_back", 1'b0, 32'h0, 32'h12345678, 4'hF, 1'b0, 0);
    set_plan(3, 0, 3, 0, 1, 0, 0, 0);
    run_txn("rty2_ack", 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 0);
    set_plan(3, 0, 3, 1, 3, 0, 3, 2);
    run_txn("rty_fail", 1'b1, 32'h4, 32'h11112222, 4'hF, 1'b0, 0);
    set_plan(0, 0, 0, 0, 0, 0, 0, 0);
    run_txn("bus_timeout", 1'b1, 32'h8, 32'h33334444, 4'h3, 1'b0, 0);
    set_plan(2, 0, 1, 0, 0, 0, 0, 0);
    run_txn("err_first", 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, 0);
    set_plan(1, TIMEOUT - 1, 0, 0, 0, 0, 0, 0);
    run_txn("ack_on_last", 1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, 1'b0, 0);
    set_plan(1, 0, 0, 0, 0, 0, 0, 0);
    irq_d = 10;
    run_txn("irq_wait10", 1'b1, 32'h14, 32'hCAFEF00D, 4'hF, 1'b1, 0);
    irq_d = 0;
    run_txn("irq_early", 1'b0, 32'h14, 32'h0, 4'hF, 1'b1, 0);
`ifdef WB_CFG_IRQ_TIMEOUT_EN
    irq_d = 1000;
    run_txn("irq_timeout", 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 0);
`endif
    run_txn("rsp_hold5", 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 5);

    // Reset mid-cycle: no response, bus released immediately.
    set_plan(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge p_clk);
    cur_adr = 32'h20; cur_dat = 32'h55AA55AA; cur_sel = 4'hF; cur_we = 1'b1; cur_wi = 1'b0;
    txn_id++;
    cmd_we = 1'b1; cmd_adr = 32'h20; cmd_dat = 32'h55AA55AA; cmd_sel = 4'hF; cmd_wait_irq = 1'b0;
    cmd_valid = 1'b1;
    @(negedge p_clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge p_clk);
    check("midreset/stb_before", p_wb_STB_O, 1);
    @(posedge p_clk);
    #2 p_reset = 1'b1;
    #1;
    check("midreset/bus_drop", {p_wb_CYC_O, p_wb_STB_O, busy, rsp_valid}, 4'b0000);
    check("midreset/regs", {p_wb_ADR_O, rsp_dat, rsp_status}, '0);
    @(negedge p_clk);
    p_reset = 1'b0;
    repeat (3) begin
      @(negedge p_clk);
      check("midreset/no_rsp", {rsp_valid, cmd_ready, p_wb_STB_O}, 3'b010);
    end

    for (int t = 0; t < 40; t++) begin
      for (int a = 0; a < 8; a++) begin
        r = $urandom_range(0, 9);
        plan_kind[a]  = (r == 0) ? 0 : (r == 1) ? 2 : (r <= 4) ? 3 : 1;
        plan_delay[a] = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : $urandom_range(0, 3);
      end
      irq_d = $urandom_range(0, 12);
      ra = $urandom; rd = $urandom;
      run_txn("random", 1'($urandom_range(0, 1)), ra, rd, 4'($urandom_range(1, 15)),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
